// File: rtl/bp_me_wb_client.sv
// Wishbone B4 classic slave that bridges single-beat WB cycles onto a BedRock
// uncached mem_fwd/mem_rev port, one transaction outstanding at a time.
module bp_me_wb_client #(
  parameter int paddr_width_p  = 40,
  parameter int did_width_p    = 3,
  parameter int lce_id_width_p = 4,
  parameter int data_width_p   = 64,
  parameter logic [did_width_p-1:0]    src_did_p    = '0,
  parameter logic [lce_id_width_p-1:0] src_lce_id_p = '0,
  localparam int mem_fwd_header_width_lp = lce_id_width_p + did_width_p + 3 + paddr_width_p + 4,
  localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [paddr_width_p-4:0]           adr_i,
  input  logic [data_width_p-1:0]            dat_i,
  input  logic                               cyc_i,
  input  logic                               stb_i,
  input  logic [data_width_p/8-1:0]          sel_i,
  input  logic                               we_i,
  input  logic [2:0]                         cti_i,
  input  logic [1:0]                         bte_i,
  output logic [data_width_p-1:0]            dat_o,
  output logic                               ack_o,
  output logic                               err_o,
  output logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_o,
  output logic [data_width_p-1:0]            mem_fwd_data_o,
  output logic                               mem_fwd_v_o,
  input  logic                               mem_fwd_ready_and_i,
  output logic                               mem_fwd_last_o,
  input  logic [mem_rev_header_width_lp-1:0] mem_rev_header_i,
  input  logic [data_width_p-1:0]            mem_rev_data_i,
  input  logic                               mem_rev_v_i,
  output logic                               mem_rev_ready_and_o,
  input  logic                               mem_rev_last_i
);

  localparam logic [3:0] UcRd = 4'd2;
  localparam logic [3:0] UcWr = 4'd3;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lceId;
    logic [did_width_p-1:0]    srcDid;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                msgType;
  } fwdHeader_t;

  typedef enum logic [2:0] {
    eIdle, eSend, eWait, eResp, eErr
  } state_e;

  state_e                  state_q;
  fwdHeader_t              fwdHeader_q, fwdHeader_d;
  logic [data_width_p-1:0] fwdData_q, fwdData_d;
  logic [data_width_p-1:0] datOut_q;
  logic                    we_q, ack_q, err_q, fwdV_q, revReady_q;

  logic                    selLegal;
  logic [2:0]              selSize;
  logic [2:0]              selLsb;
  logic [data_width_p-1:0] shifted;

  // The sideband fields carry nothing this single-beat bridge needs.
  logic unusedInputs;
  assign unusedInputs = &{1'b0, cti_i, bte_i, mem_rev_header_i, mem_rev_last_i};

  // Only naturally aligned power-of-two byte groups map onto a BedRock size.
  always_comb begin
    selLegal = 1'b1;
    selSize  = 3'd0;
    selLsb   = 3'd0;
    case (sel_i)
      8'h01: selLsb = 3'd0;
      8'h02: selLsb = 3'd1;
      8'h04: selLsb = 3'd2;
      8'h08: selLsb = 3'd3;
      8'h10: selLsb = 3'd4;
      8'h20: selLsb = 3'd5;
      8'h40: selLsb = 3'd6;
      8'h80: selLsb = 3'd7;
      8'h03: begin selSize = 3'd1; selLsb = 3'd0; end
      8'h0C: begin selSize = 3'd1; selLsb = 3'd2; end
      8'h30: begin selSize = 3'd1; selLsb = 3'd4; end
      8'hC0: begin selSize = 3'd1; selLsb = 3'd6; end
      8'h0F: begin selSize = 3'd2; selLsb = 3'd0; end
      8'hF0: begin selSize = 3'd2; selLsb = 3'd4; end
      8'hFF: begin selSize = 3'd3; selLsb = 3'd0; end
      default: selLegal = 1'b0;
    endcase
  end

  // BedRock expects the addressed bytes replicated across the whole data word.
  always_comb begin
    shifted = dat_i >> {selLsb, 3'b000};
    case (selSize)
      3'd0:    fwdData_d = {8{shifted[7:0]}};
      3'd1:    fwdData_d = {4{shifted[15:0]}};
      3'd2:    fwdData_d = {2{shifted[31:0]}};
      default: fwdData_d = shifted;
    endcase
    fwdHeader_d         = '0;
    fwdHeader_d.msgType = we_i ? UcWr : UcRd;
    fwdHeader_d.addr    = {adr_i, selLsb};
    fwdHeader_d.size    = selSize;
    fwdHeader_d.srcDid  = src_did_p;
    fwdHeader_d.lceId   = src_lce_id_p;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= eIdle;
      fwdHeader_q <= '0;
      fwdData_q   <= '0;
      datOut_q    <= '0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      fwdV_q      <= 1'b0;
      revReady_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        eIdle: begin
          if (cyc_i && stb_i) begin
            if (selLegal) begin
              fwdHeader_q <= fwdHeader_d;
              fwdData_q   <= fwdData_d;
              we_q        <= we_i;
              fwdV_q      <= 1'b1;
              state_q     <= eSend;
            end else begin
              err_q   <= 1'b1;
              state_q <= eErr;
            end
          end
        end
        eSend: begin
          if (mem_fwd_ready_and_i) begin
            fwdV_q     <= 1'b0;
            revReady_q <= 1'b1;
            state_q    <= eWait;
          end
        end
        // A master that abandoned its cycle still lets the response drain.
        eWait: begin
          if (mem_rev_v_i) begin
            revReady_q <= 1'b0;
            ack_q      <= cyc_i & stb_i;
            datOut_q   <= we_q ? '0 : mem_rev_data_i;
            state_q    <= eResp;
          end
        end
        eResp: begin
          datOut_q <= '0;
          state_q  <= eIdle;
        end
        default: state_q <= eIdle;
      endcase
    end
  end

  assign dat_o               = datOut_q;
  assign ack_o               = ack_q;
  assign err_o               = err_q;
  assign mem_fwd_header_o    = fwdHeader_q;
  assign mem_fwd_data_o      = fwdData_q;
  assign mem_fwd_v_o         = fwdV_q;
  assign mem_fwd_last_o      = fwdV_q;
  assign mem_rev_ready_and_o = revReady_q;

endmodule

// File: tb/tb_bp_me_wb_client.sv
// Randomised bench for bp_me_wb_client: acts as WB master and BedRock memory,
// checking against a byte-level reference model of the sel/header rules.
module tb_bp_me_wb_client;

  localparam int HdrW = 4 + 3 + 3 + 40 + 4;

  logic            clk = 1'b0;
  logic            resetN;
  logic [36:0]     adr;
  logic [63:0]     datIn;
  logic            cyc, stb, we;
  logic [7:0]      sel;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [63:0]     datOut;
  logic            ack, err;
  logic [HdrW-1:0] fwdHeader;
  logic [63:0]     fwdData;
  logic            fwdV, fwdReady, fwdLast;
  logic [HdrW-1:0] revHeader;
  logic [63:0]     revData;
  logic            revV, revReady, revLast;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  bp_me_wb_client #(
    .paddr_width_p(40), .did_width_p(3), .lce_id_width_p(4), .data_width_p(64),
    .src_did_p(3'd5), .src_lce_id_p(4'd9)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN),
    .adr_i(adr), .dat_i(datIn), .cyc_i(cyc), .stb_i(stb), .sel_i(sel), .we_i(we),
    .cti_i(cti), .bte_i(bte), .dat_o(datOut), .ack_o(ack), .err_o(err),
    .mem_fwd_header_o(fwdHeader), .mem_fwd_data_o(fwdData), .mem_fwd_v_o(fwdV),
    .mem_fwd_ready_and_i(fwdReady), .mem_fwd_last_o(fwdLast),
    .mem_rev_header_i(revHeader), .mem_rev_data_i(revData), .mem_rev_v_i(revV),
    .mem_rev_ready_and_o(revReady), .mem_rev_last_i(revLast)
  );

  // Reference model: legality, size code, byte offset and replicated write data.
  function automatic void model(input logic [7:0] s, input logic [63:0] d,
                                output bit legal, output logic [2:0] size,
                                output logic [2:0] lsb, output logic [63:0] wdata);
    int n, lo;
    logic [8:0] pat;
    logic [63:0] v;
    n = $countones(s);
    lo = 0;
    for (int i = 7; i >= 0; i--) if (s[i]) lo = i;
    pat = ((9'd1 << n) - 9'd1) << lo;
    legal = (n == 1 || n == 2 || n == 4 || n == 8) && (pat[7:0] == s) && (lo % n == 0);
    size = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : (n == 4) ? 3'd2 : 3'd3;
    lsb = 3'(lo);
    v = d >> (8 * lo);
    wdata = '0;
    for (int i = 0; i < 8; i++)
      if (n > 0) wdata[8*i +: 8] = v[8*(i % n) +: 8];
  endfunction

  function automatic logic [HdrW-1:0] expHeader(input logic [36:0] a, input bit w,
                                                input logic [2:0] size, input logic [2:0] lsb);
    return {4'd9, 3'd5, size, {a, lsb}, (w ? 4'd3 : 4'd2)};
  endfunction

  // Drives one WB request and plays the memory side; records what was observed.
  task automatic run_txn(input logic [36:0] a, input logic [7:0] s, input bit w,
                         input logic [63:0] d, input logic [63:0] rdata,
                         input int fwdStall, input int revStall, input bit dropInWait,
                         output logic [HdrW-1:0] hdr, output logic [63:0] fdata,
                         output bit hdrStable, output int fwdCycles, output int ackCount,
                         output int ackCycle, output logic [63:0] ackData,
                         output int errCount, output int errCycle, output bit bothHigh,
                         output bit timedOut);
    int cycle, stallCnt, revCnt, tail;
    bit done;
    hdr = '0; fdata = '0; hdrStable = 1; fwdCycles = 0; ackCount = 0; ackCycle = -1;
    ackData = '0; errCount = 0; errCycle = -1; bothHigh = 0; timedOut = 1;
    stallCnt = 0; revCnt = 0; tail = 0; done = 0;
    @(posedge clk); #1;
    adr = a; sel = s; we = w; datIn = d; cyc = 1; stb = 1;
    cti = 3'($urandom); bte = 2'($urandom);
    cycle = 0;
    while (cycle < 300) begin
      @(negedge clk);
      if (fwdV) begin
        if (fwdCycles == 0) begin
          hdr = fwdHeader; fdata = fwdData;
        end else if (hdr !== fwdHeader || fdata !== fwdData || fwdLast !== 1'b1) begin
          hdrStable = 0;
        end
        fwdCycles++;
        fwdReady = (stallCnt >= fwdStall);
        if (!fwdReady) stallCnt++;
      end else begin
        fwdReady = 0;
      end
      if (revReady) begin
        if (dropInWait) begin cyc = 0; stb = 0; end
        if (revCnt >= revStall) begin
          revV = 1; revData = rdata;
          if (dropInWait) done = 1;
        end else begin
          revV = 0; revData = 64'($urandom) << 17; revCnt++;
        end
      end else begin
        revV = 0;
      end
      if (ack && err) bothHigh = 1;
      if (ack) begin
        ackCount++;
        if (ackCycle < 0) begin ackCycle = cycle; ackData = datOut; end
        cyc = 0; stb = 0; done = 1;
      end
      if (err) begin
        errCount++;
        if (errCycle < 0) errCycle = cycle;
        cyc = 0; stb = 0; done = 1;
      end
      if (done) begin
        if (tail == 3) begin timedOut = 0; break; end
        tail++;
      end
      @(posedge clk); #1;
      cycle++;
    end
    fwdReady = 0; revV = 0; cyc = 0; stb = 0;
  endtask

  task automatic test_reset();
    resetN = 0; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; datIn = '0;
    cti = '0; bte = '0; fwdReady = 0; revV = 0; revData = '0; revHeader = '0; revLast = 1;
    #23;
    nCompared++;
    if ({ack, err, fwdV, fwdLast, revReady} !== 5'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {ack, err, fwdV, fwdLast, revReady});
    end
    nCompared++;
    if (datOut !== 64'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_dat: got %h expected 0", datOut);
    end
    nCompared++;
    if (fwdHeader !== '0 || fwdData !== 64'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_fwd: hdr %h data %h expected 0", fwdHeader, fwdData);
    end
    @(negedge clk); resetN = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_full();
    logic [HdrW-1:0] h; logic [63:0] fd, ad; bit st, both, to; int fc, ac, acy, ec, ecy;
    run_txn(37'h100, 8'hFF, 0, 64'h1234, 64'hDEADBEEF_CAFEF00D, 0, 0, 0,
            h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
    nCompared++;
    if (h !== {4'd9, 3'd5, 3'd3, 40'h800, 4'd2}) begin
      nMismatched++; $display("[TB] FAIL read_hdr: got %h expected %h", h, {4'd9, 3'd5, 3'd3, 40'h800, 4'd2});
    end
    nCompared++;
    if (ac !== 1 || acy !== 3 || to) begin
      nMismatched++; $display("[TB] FAIL read_ack: count %0d cycle %0d timeout %0d expected 1/3/0", ac, acy, to);
    end
    nCompared++;
    if (ad !== 64'hDEADBEEF_CAFEF00D) begin
      nMismatched++; $display("[TB] FAIL read_dat: got %h expected deadbeefcafef00d", ad);
    end
  endtask

  task automatic test_write_half();
    logic [HdrW-1:0] h; logic [63:0] fd, ad; bit st, both, to; int fc, ac, acy, ec, ecy;
    run_txn(37'h2A, 8'h30, 1, 64'h0000_BEEF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 0,
            h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
    nCompared++;
    if (h !== {4'd9, 3'd5, 3'd1, 40'h154, 4'd3}) begin
      nMismatched++; $display("[TB] FAIL write_hdr: got %h expected %h", h, {4'd9, 3'd5, 3'd1, 40'h154, 4'd3});
    end
    nCompared++;
    if (fd !== 64'hBEEF_BEEF_BEEF_BEEF) begin
      nMismatched++; $display("[TB] FAIL write_data: got %h expected beefbeefbeefbeef", fd);
    end
    nCompared++;
    if (ac !== 1 || acy !== 5 || ad !== 64'd0) begin
      nMismatched++; $display("[TB] FAIL write_ack: count %0d cycle %0d dat %h expected 1/5/0", ac, acy, ad);
    end
  endtask

  task automatic test_illegal_sel();
    logic [HdrW-1:0] h; logic [63:0] fd, ad; bit st, both, to; int fc, ac, acy, ec, ecy;
    logic [7:0] bad [2] = '{8'h05, 8'h00};
    for (int i = 0; i < 2; i++) begin
      run_txn(37'h77, bad[i], 0, 64'h0, 64'h0, 0, 0, 0, h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
      nCompared++;
      if (ec !== 1 || ecy !== 1 || to) begin
        nMismatched++; $display("[TB] FAIL illegal_err sel=%h: count %0d cycle %0d expected 1/1", bad[i], ec, ecy);
      end
      nCompared++;
      if (fc !== 0 || ac !== 0) begin
        nMismatched++; $display("[TB] FAIL illegal_quiet sel=%h: fwd %0d ack %0d expected 0/0", bad[i], fc, ac);
      end
    end
  endtask

  task automatic test_fwd_stall();
    logic [HdrW-1:0] h; logic [63:0] fd, ad; bit st, both, to; int fc, ac, acy, ec, ecy;
    run_txn(37'h1F00, 8'h0F, 1, 64'h0123_4567_89AB_CDEF, 64'h0, 10, 0, 0,
            h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
    nCompared++;
    if (!st || fc !== 11) begin
      nMismatched++; $display("[TB] FAIL stall_hold: stable %0d fwd cycles %0d expected 1/11", st, fc);
    end
    nCompared++;
    if (fd !== 64'h89AB_CDEF_89AB_CDEF || ac !== 1 || acy !== 13) begin
      nMismatched++; $display("[TB] FAIL stall_done: data %h ack %0d cycle %0d expected 89abcdef89abcdef/1/13", fd, ac, acy);
    end
  endtask

  task automatic test_drop_cyc();
    logic [HdrW-1:0] h; logic [63:0] fd, ad; bit st, both, to; int fc, ac, acy, ec, ecy;
    run_txn(37'h40, 8'h02, 0, 64'h0, 64'h5555_5555_5555_5555, 0, 3, 1,
            h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
    nCompared++;
    if (ac !== 0 || to) begin
      nMismatched++; $display("[TB] FAIL drop_ack: count %0d timeout %0d expected 0/0", ac, to);
    end
    run_txn(37'h41, 8'h80, 0, 64'h0, 64'h7777_7777_7777_7777, 0, 0, 0,
            h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
    nCompared++;
    if (ac !== 1 || acy !== 3 || ad !== 64'h7777_7777_7777_7777) begin
      nMismatched++; $display("[TB] FAIL drop_next: count %0d cycle %0d dat %h expected 1/3/7777777777777777", ac, acy, ad);
    end
  endtask

  task automatic test_reset_mid();
    logic [HdrW-1:0] h; logic [63:0] fd, ad; bit st, both, to; int fc, ac, acy, ec, ecy;
    @(posedge clk); #1;
    adr = 37'h99; sel = 8'hFF; we = 0; datIn = '0; cyc = 1; stb = 1;
    @(negedge clk);
    @(negedge clk);
    nCompared++;
    if (fwdV !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL midreset_send: fwd_v %b expected 1", fwdV);
    end
    resetN = 0; cyc = 0; stb = 0;
    #1;
    nCompared++;
    if (fwdV !== 1'b0 || ack !== 1'b0 || fwdLast !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL midreset_drop: fwd_v %b ack %b last %b expected 0", fwdV, ack, fwdLast);
    end
    repeat (2) @(negedge clk);
    resetN = 1;
    run_txn(37'h9A, 8'h0C, 0, 64'h0, 64'h0A0B_0C0D_0E0F_1011, 0, 0, 0,
            h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
    nCompared++;
    if (ac !== 1 || acy !== 3 || fc !== 1) begin
      nMismatched++; $display("[TB] FAIL midreset_idle: ack %0d cycle %0d fwd %0d expected 1/3/1", ac, acy, fc);
    end
  endtask

  task automatic test_random();
    logic [HdrW-1:0] h; logic [63:0] fd, ad; bit st, both, to; int fc, ac, acy, ec, ecy;
    logic [36:0] a; logic [7:0] s; logic [63:0] d, r, ew; logic [2:0] esz, elsb;
    bit w, legal; int n, fs, rs;
    for (int it = 0; it < 40; it++) begin
      a = {5'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        s = 8'($urandom);
      end else begin
        n = 1 << $urandom_range(0, 3);
        s = 8'(((1 << n) - 1) << (n * $urandom_range(0, 8 / n - 1)));
      end
      w = 1'($urandom); d = {32'($urandom), 32'($urandom)}; r = {32'($urandom), 32'($urandom)};
      fs = $urandom_range(0, 3); rs = $urandom_range(0, 3);
      model(s, d, legal, esz, elsb, ew);
      run_txn(a, s, w, d, r, fs, rs, 0, h, fd, st, fc, ac, acy, ad, ec, ecy, both, to);
      nCompared++;
      if (both || to) begin
        nMismatched++; $display("[TB] FAIL rand_proto it=%0d: both %0d timeout %0d expected 0/0", it, both, to);
      end
      if (legal) begin
        nCompared++;
        if (ec !== 0 || ac !== 1 || acy !== 3 + fs + rs) begin
          nMismatched++; $display("[TB] FAIL rand_ack it=%0d sel=%h: err %0d ack %0d cycle %0d expected 0/1/%0d", it, s, ec, ac, acy, 3 + fs + rs);
        end
        nCompared++;
        if (h !== expHeader(a, w, esz, elsb)) begin
          nMismatched++; $display("[TB] FAIL rand_hdr it=%0d sel=%h: got %h expected %h", it, s, h, expHeader(a, w, esz, elsb));
        end
        nCompared++;
        if (fd !== ew) begin
          nMismatched++; $display("[TB] FAIL rand_wdata it=%0d sel=%h: got %h expected %h", it, s, fd, ew);
        end
        nCompared++;
        if (ad !== (w ? 64'd0 : r)) begin
          nMismatched++; $display("[TB] FAIL rand_rdata it=%0d: got %h expected %h", it, ad, (w ? 64'd0 : r));
        end
      end else begin
        nCompared++;
        if (ec !== 1 || fc !== 0 || ac !== 0) begin
          nMismatched++; $display("[TB] FAIL rand_illegal it=%0d sel=%h: err %0d fwd %0d ack %0d expected 1/0/0", it, s, ec, fc, ac);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_full();
    test_write_half();
    test_illegal_sel();
    test_fwd_stall();
    test_drop_cyc();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
